// File: rtl/heartbeat_monitor_pkg.sv
// heartbeat_monitor_pkg: FSM state encodings and period/width derivations
// shared by the heartbeat monitor and the heartbeat generator bench.
package heartbeat_monitor_pkg;
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } hb_state_t;
  function automatic int p_of(input int f_clkin, input int t_ms);
    return f_clkin * t_ms;
  endfunction
  function automatic int cw_of(input int p_max);
    return $clog2(p_max + 2);
  endfunction
endpackage

// File: rtl/heartbeat_monitor_if.sv
// heartbeat_monitor_if: heartbeat input, clear and status outputs of the monitor.
interface heartbeat_monitor_if #(
  parameter int CW = 8
);
  logic          hb;
  logic          clr;
  logic          alive;
  logic          lost;
  logic [CW-1:0] period;
  logic          period_vld;
  logic [7:0]    err_cnt;
  modport master (output hb, clr, input alive, lost, period, period_vld, err_cnt);
  modport slave  (input hb, clr, output alive, lost, period, period_vld, err_cnt);
endinterface

// File: rtl/heartbeat_sync_edge.sv
// heartbeat_sync_edge: 2-flop synchronizer, optional 3-sample stable filter
// (HEARTBEAT_MONITOR_FILTER_EN), registered rising-edge strobe.
module heartbeat_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic hb,
  output logic rise
);
  logic s1, s2, lvl, lvl_d;
`ifdef HEARTBEAT_MONITOR_FILTER_EN
  logic [1:0] h;
  logic       f;
  // the level only follows s2 once it and its two predecessors agree
  assign lvl = (s2 == h[0] && h[0] == h[1]) ? s2 : f;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h <= '0;
      f <= 1'b0;
    end else begin
      h <= {h[0], s2};
      f <= lvl;
    end
`else
  assign lvl = s2;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl_d <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1    <= hb;
      s2    <= s1;
      lvl_d <= lvl;
      rise  <= lvl & ~lvl_d;
    end
endmodule

// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: measures a heartbeat period and tracks lock/alive/lost;
// HEARTBEAT_MONITOR_FILTER_EN enables the glitch filter in heartbeat_sync_edge.
module heartbeat_monitor
  import heartbeat_monitor_pkg::*;
#(
  parameter int f_clkin  = 12000,
  parameter int t_min_ms = 800,
  parameter int t_max_ms = 1200,
  parameter int n_lock   = 3
) (
  input logic               clk,
  input logic               rst_n,
  heartbeat_monitor_if.slave bus
);
  localparam int P_MIN = p_of(f_clkin, t_min_ms);
  localparam int P_MAX = p_of(f_clkin, t_max_ms);
  localparam int CW    = cw_of(P_MAX);
  localparam int GW    = $clog2(n_lock + 1);
  localparam logic [CW-1:0] C_MIN = CW'(P_MIN);
  localparam logic [CW-1:0] C_MAX = CW'(P_MAX);
  localparam logic [CW-1:0] C_TO  = CW'(P_MAX + 1);
  hb_state_t     state, nxt;
  logic          rise, in_rng, tmo, report, err_inc, lost_set;
  logic [CW-1:0] cnt, period;
  logic [GW-1:0] good, good_n;
  logic          alive, lost, period_vld;
  logic [7:0]    err_cnt;
  heartbeat_sync_edge u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .hb   (bus.hb),
    .rise (rise)
  );
  assign in_rng = cnt >= C_MIN && cnt <= C_MAX;
  assign tmo    = cnt == C_TO;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (rise) cnt <= CW'(1);
    else if (!tmo) cnt <= cnt + CW'(1);
  always_comb begin
    nxt      = state;
    good_n   = good;
    report   = 1'b0;
    err_inc  = 1'b0;
    lost_set = 1'b0;
    unique case (state)
      SEARCH: if (rise) begin
        nxt    = ACQ;
        good_n = '0;
      end
      ACQ: if (rise) begin
        report = 1'b1;
        good_n = in_rng ? good + GW'(1) : '0;
        nxt    = (in_rng && good_n == GW'(n_lock)) ? LOCKED : ACQ;
      end else if (tmo) nxt = SEARCH;
      LOCKED: if (rise) begin
        report  = 1'b1;
        nxt     = in_rng ? LOCKED : ACQ;
        good_n  = '0;
        err_inc = !in_rng;
      end else if (tmo) begin
        nxt      = SEARCH;
        lost_set = 1'b1;
        err_inc  = 1'b1;
      end
      default: nxt = SEARCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= SEARCH;
      good       <= '0;
      alive      <= 1'b0;
      lost       <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= nxt;
      good       <= good_n;
      alive      <= nxt == LOCKED;
      period_vld <= report;
      if (report) period <= cnt;
      lost       <= bus.clr ? 1'b0 : lost | lost_set;
      err_cnt    <= bus.clr ? 8'd0 : (err_inc && err_cnt != 8'hff) ? err_cnt + 8'd1 : err_cnt;
    end
  assign bus.alive      = alive;
  assign bus.lost       = lost;
  assign bus.period     = period;
  assign bus.period_vld = period_vld;
  assign bus.err_cnt    = err_cnt;
endmodule

// File: tb/tb_heartbeat_monitor.sv
// tb_heartbeat_monitor: directed bench, f_clkin=1, periods 96..144, n_lock=3.
module tb_heartbeat_monitor;
  localparam int CW = 8;
`ifdef HEARTBEAT_MONITOR_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int last_per = 0;
  heartbeat_monitor_if #(.CW(CW)) bus ();
  heartbeat_monitor #(
    .f_clkin (1),
    .t_min_ms(96),
    .t_max_ms(144),
    .n_lock  (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.period_vld === 1'b1) begin
      vld_cnt++;
      last_per = int'(bus.period);
    end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wave(input int p, input int n);
    repeat (n) begin
      bus.hb = 1'b1;
      tick(p / 2);
      bus.hb = 1'b0;
      tick(p - p / 2);
    end
  endtask
  task automatic test_reset;
    bus.hb  = 1'b0;
    bus.clr = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      bus.hb = ~bus.hb;
    end
    checks++;
    if ({bus.alive, bus.lost, bus.period_vld, bus.period, bus.err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_held: got alive=%b lost=%b vld=%b period=%0d err=%0d, want all 0",
               bus.alive, bus.lost, bus.period_vld, bus.period, bus.err_cnt);
    end
    bus.hb = 1'b0;
    rst_n  = 1'b1;
    tick(10);
    checks++;
    if ({bus.alive, bus.lost, bus.period_vld, bus.period, bus.err_cnt} !== '0 || vld_cnt != 0) begin
      errors++;
      $display("FAIL reset_release: got alive=%b lost=%b period=%0d err=%0d vlds=%0d, want all 0",
               bus.alive, bus.lost, bus.period, bus.err_cnt, vld_cnt);
    end
  endtask
  task automatic test_lock;
    int base = vld_cnt;
    wave(120, 3);
    checks++;
    if (bus.alive !== 1'b0 || vld_cnt - base != 2 || last_per != 120) begin
      errors++;
      $display("FAIL lock_3_edges: got alive=%b vlds=%0d period=%0d, want 0 2 120",
               bus.alive, vld_cnt - base, last_per);
    end
    wave(120, 2);
    checks++;
    if (bus.alive !== 1'b1 || vld_cnt - base != 4 || last_per != 120) begin
      errors++;
      $display("FAIL lock_5_edges: got alive=%b vlds=%0d period=%0d, want 1 4 120",
               bus.alive, vld_cnt - base, last_per);
    end
  endtask
  task automatic test_latency;
    int k = 0;
    bus.hb = 1'b1;
    tick(1);
    while (bus.period_vld !== 1'b1 && k < 12) begin
      tick(1);
      k++;
    end
    checks++;
    if (k != LAT || bus.period !== CW'(120)) begin
      errors++;
      $display("FAIL vld_latency: got %0d clk period=%0d, want %0d clk period=120", k, bus.period, LAT);
    end
    tick(1);
    checks++;
    if (bus.period_vld !== 1'b0) begin
      errors++;
      $display("FAIL vld_one_cycle: got vld=%b, want 0", bus.period_vld);
    end
    tick(60 - (k + 2));
    bus.hb = 1'b0;
    tick(60);
  endtask
  task automatic test_timeout;
    tick(15);
    checks++;
    if (bus.alive !== 1'b1 || bus.lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got alive=%b lost=%b, want 1 0", bus.alive, bus.lost);
    end
    tick(20);
    checks++;
    if (bus.alive !== 1'b0 || bus.lost !== 1'b1 || bus.err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL timeout_lost: got alive=%b lost=%b err=%0d, want 0 1 1", bus.alive, bus.lost, bus.err_cnt);
    end
  endtask
  task automatic test_short;
    wave(120, 5);
    checks++;
    if (bus.alive !== 1'b1) begin
      errors++;
      $display("FAIL relock_after_search: got alive=%b, want 1", bus.alive);
    end
    wave(50, 1);
    wave(120, 1);
    checks++;
    if (last_per != 50 || bus.alive !== 1'b0 || bus.err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL short_period: got period=%0d alive=%b err=%0d, want 50 0 2", last_per, bus.alive, bus.err_cnt);
    end
    wave(120, 3);
    checks++;
    if (bus.alive !== 1'b1 || bus.err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL relock_after_short: got alive=%b err=%0d, want 1 2", bus.alive, bus.err_cnt);
    end
  endtask
  task automatic test_boundary;
    wave(96, 1);
    wave(144, 1);
    checks++;
    if (last_per != 96 || bus.alive !== 1'b1) begin
      errors++;
      $display("FAIL bound_min: got period=%0d alive=%b, want 96 1", last_per, bus.alive);
    end
    wave(120, 1);
    checks++;
    if (last_per != 144 || bus.alive !== 1'b1 || bus.err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL bound_max: got period=%0d alive=%b err=%0d, want 144 1 2", last_per, bus.alive, bus.err_cnt);
    end
    wave(95, 1);
    wave(120, 1);
    checks++;
    if (last_per != 95 || bus.alive !== 1'b0 || bus.err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL bound_below_min: got period=%0d alive=%b err=%0d, want 95 0 3", last_per, bus.alive, bus.err_cnt);
    end
    wave(120, 3);
    checks++;
    if (bus.alive !== 1'b1) begin
      errors++;
      $display("FAIL bound_relock: got alive=%b, want 1", bus.alive);
    end
  endtask
  task automatic test_clear;
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    checks++;
    if (bus.lost !== 1'b0 || bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_pulse: got lost=%b err=%0d, want 0 0", bus.lost, bus.err_cnt);
    end
    tick(26);
    checks++;
    if (bus.alive !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre_timeout: got alive=%b, want 1", bus.alive);
    end
    bus.clr = 1'b1;
    tick(3);
    bus.clr = 1'b0;
    tick(5);
    checks++;
    if (bus.alive !== 1'b0 || bus.lost !== 1'b0 || bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_vs_timeout: got alive=%b lost=%b err=%0d, want 0 0 0", bus.alive, bus.lost, bus.err_cnt);
    end
  endtask
  task automatic test_glitch;
    wave(120, 5);
    bus.hb = 1'b1;
    tick(60);
    bus.hb = 1'b0;
    tick(30);
    bus.hb = 1'b1;
    tick(1);
    bus.hb = 1'b0;
    tick(29);
    checks++;
`ifdef HEARTBEAT_MONITOR_FILTER_EN
    if (bus.alive !== 1'b1 || bus.err_cnt !== 8'd0 || last_per != 120) begin
      errors++;
      $display("FAIL glitch: got alive=%b err=%0d period=%0d, want 1 0 120", bus.alive, bus.err_cnt, last_per);
    end
`else
    if (bus.alive !== 1'b0 || bus.err_cnt !== 8'd1 || last_per != 90) begin
      errors++;
      $display("FAIL glitch: got alive=%b err=%0d period=%0d, want 0 1 90", bus.alive, bus.err_cnt, last_per);
    end
`endif
    wave(120, 4);
    checks++;
    if (bus.alive !== 1'b1) begin
      errors++;
      $display("FAIL glitch_relock: got alive=%b, want 1", bus.alive);
    end
  endtask
  task automatic test_async_reset;
    int base;
    bus.hb = 1'b1;
    tick(10);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.alive, bus.lost, bus.period_vld, bus.period, bus.err_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: got alive=%b lost=%b period=%0d err=%0d, want all 0",
               bus.alive, bus.lost, bus.period, bus.err_cnt);
    end
    bus.hb = 1'b0;
    tick(2);
    rst_n = 1'b1;
    base  = vld_cnt;
    wave(120, 1);
    checks++;
    if (vld_cnt != base || bus.alive !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_first_edge: got vlds=%0d alive=%b, want 0 0", vld_cnt - base, bus.alive);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_lock();
    test_latency();
    test_timeout();
    test_short();
    test_boundary();
    test_clear();
    test_glitch();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
